parity_frame_rx: RTL and testbench

PARITY_FRAME_RX -- requirements
Module: parity_frame_rx

---
 rtl/parity_frame_rx_pkg.sv | 14 +
 rtl/parity_frame_rx_obuf.sv | 81 ++++++++
 rtl/parity_frame_rx.sv | 108 ++++++++++
 tb/tb_parity_frame_rx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/parity_frame_rx_pkg.sv
// Shared types and frame-field constants for the parity frame receiver.
package parity_frame_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } state_e;

  localparam logic StartBit = 1'b0;
  localparam logic StopBit  = 1'b1;

endpackage

// File: rtl/parity_frame_rx_obuf.sv
// One-entry output buffer for received words; flags overrun when a completed
// frame arrives while the held word is still waiting for the consumer.
module parity_frame_rx_obuf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              par_err_i,
  input  logic              frm_err_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              par_err_o,
  output logic              frm_err_o,
  output logic              all_zero_o,
  output logic              all_one_o,
  output logic              valid_o,
  output logic              overrun_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              par_err_q, par_err_d;
  logic              frm_err_q, frm_err_d;
  logic              all_zero_q, all_zero_d;
  logic              all_one_q, all_one_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  always_comb begin
    data_d     = data_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    all_zero_d = all_zero_q;
    all_one_d  = all_one_q;
    valid_d    = valid_q;
    overrun_d  = 1'b0;
    if (load_i && (!valid_q || ready_i)) begin
      // Buffer is free, or is being drained this very cycle.
      data_d     = word_i;
      par_err_d  = par_err_i;
      frm_err_d  = frm_err_i;
      all_zero_d = ~|word_i;
      all_one_d  = &word_i;
      valid_d    = 1'b1;
    end else if (load_i) begin
      overrun_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      all_zero_q <= 1'b1;
      all_one_q  <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      data_q     <= data_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      all_zero_q <= all_zero_d;
      all_one_q  <= all_one_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign data_o     = data_q;
  assign par_err_o  = par_err_q;
  assign frm_err_o  = frm_err_q;
  assign all_zero_o = all_zero_q;
  assign all_one_o  = all_one_q;
  assign valid_o    = valid_q;
  assign overrun_o  = overrun_q;

endmodule

// File: rtl/parity_frame_rx.sv
// Strobed serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Completed frames are handed to a one-entry output buffer.
module parity_frame_rx
  import parity_frame_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdi,
  input  logic              sdi_en,
  output logic [DATA_W-1:0] data,
  output logic              par_err,
  output logic              frm_err,
  output logic              all_zero,
  output logic              all_one,
  output logic              valid,
  input  logic              ready,
  output logic              overrun
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);
  localparam logic ParOdd = (PARITY_ODD != 0);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              done;
  logic              rx_par_err;
  logic              rx_frm_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    done    = 1'b0;
    if (sdi_en) begin
      unique case (state_q)
        StIdle: begin
          if (sdi == StartBit) begin
            state_d = StData;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
        StData: begin
          shift_d[cnt_q] = sdi;
          // Counter parks on the last index instead of wrapping.
          if (cnt_q == CntLast) begin
            state_d = StParity;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StParity: begin
          par_d   = sdi;
          state_d = StStop;
        end
        StStop: begin
          done    = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign rx_par_err = (^shift_q) ^ par_q ^ ParOdd;
  assign rx_frm_err = (sdi != StopBit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  parity_frame_rx_obuf #(
    .DATA_W(DATA_W)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (done),
    .word_i    (shift_q),
    .par_err_i (rx_par_err),
    .frm_err_i (rx_frm_err),
    .ready_i   (ready),
    .data_o    (data),
    .par_err_o (par_err),
    .frm_err_o (frm_err),
    .all_zero_o(all_zero),
    .all_one_o (all_one),
    .valid_o   (valid),
    .overrun_o (overrun)
  );

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: an even-parity and an odd-parity instance
// share one serial line and one ready input.
module tb_parity_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sdi = 1'b1;
  logic       sdi_en = 1'b0;
  logic       ready = 1'b0;

  logic [7:0] data, data_o;
  logic       par_err, frm_err, all_zero, all_one, valid, overrun;
  logic       par_err_o, frm_err_o, all_zero_o, all_one_o, valid_o, overrun_o;

  int checks = 0;
  int failures = 0;
  int ovr_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (overrun) ovr_cnt++;

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .sdi_en(sdi_en), .data(data),
    .par_err(par_err), .frm_err(frm_err), .all_zero(all_zero), .all_one(all_one),
    .valid(valid), .ready(ready), .overrun(overrun)
  );

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .sdi_en(sdi_en), .data(data_o),
    .par_err(par_err_o), .frm_err(frm_err_o), .all_zero(all_zero_o),
    .all_one(all_one_o), .valid(valid_o), .ready(ready), .overrun(overrun_o)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    sdi = b;
    sdi_en = 1'b1;
    @(negedge clk);
    sdi_en = 1'b0;
    sdi = 1'b1;
  endtask

  // Start bit, eight data bits LSB first, parity bit.
  task automatic send_head(input logic [7:0] d, input logic p);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
  endtask

  task automatic send_stop(input logic s, input logic rdy);
    @(negedge clk);
    sdi = s;
    sdi_en = 1'b1;
    ready = rdy;
    @(negedge clk);
    sdi_en = 1'b0;
    sdi = 1'b1;
    ready = 1'b0;
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk(tag, 16'(valid), 16'h0);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_data", 16'(data), 16'h0);
    chk("rst_par_err", 16'(par_err), 16'h0);
    chk("rst_frm_err", 16'(frm_err), 16'h0);
    chk("rst_all_zero", 16'(all_zero), 16'h1);
    chk("rst_all_one", 16'(all_one), 16'h0);
    chk("rst_valid", 16'(valid), 16'h0);
    chk("rst_overrun", 16'(overrun), 16'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5, even parity bit 0, good stop; valid appears right after the stop strobe
    send_head(8'hA5, 1'b0);
    chk("a5_valid_before_stop", 16'(valid), 16'h0);
    send_stop(1'b1, 1'b0);
    chk("a5_valid", 16'(valid), 16'h1);
    chk("a5_data", 16'(data), 16'hA5);
    chk("a5_par_err", 16'(par_err), 16'h0);
    chk("a5_frm_err", 16'(frm_err), 16'h0);
    chk("a5_all_zero", 16'(all_zero), 16'h0);
    chk("a5_all_one", 16'(all_one), 16'h0);
    repeat (3) @(negedge clk);
    chk("a5_held", 16'(data), 16'hA5);
    accept("a5_accept");

    // ready toggling while empty has no effect
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ready = ~ready;
    end
    ready = 1'b0;
    @(negedge clk);
    chk("idle_ready_toggle_valid", 16'(valid), 16'h0);

    // All-zero and all-one words
    send_head(8'h00, 1'b0);
    send_stop(1'b1, 1'b0);
    chk("z_data", 16'(data), 16'h00);
    chk("z_all_zero", 16'(all_zero), 16'h1);
    chk("z_all_one", 16'(all_one), 16'h0);
    chk("z_par_err", 16'(par_err), 16'h0);
    accept("z_accept");
    send_head(8'hFF, 1'b0);
    send_stop(1'b1, 1'b0);
    chk("f_data", 16'(data), 16'hFF);
    chk("f_all_zero", 16'(all_zero), 16'h0);
    chk("f_all_one", 16'(all_one), 16'h1);
    chk("f_par_err", 16'(par_err), 16'h0);
    accept("f_accept");

    // 0x01 with parity 0: bad for even, good for odd
    send_head(8'h01, 1'b0);
    send_stop(1'b1, 1'b0);
    chk("p01_even_par_err", 16'(par_err), 16'h1);
    chk("p01_odd_valid", 16'(valid_o), 16'h1);
    chk("p01_odd_data", 16'(data_o), 16'h01);
    chk("p01_odd_par_err", 16'(par_err_o), 16'h0);
    accept("p01_accept");

    // Bad stop bit, then a clean frame
    send_head(8'h3C, 1'b0);
    send_stop(1'b0, 1'b0);
    chk("fe_frm_err", 16'(frm_err), 16'h1);
    chk("fe_data", 16'(data), 16'h3C);
    chk("fe_par_err", 16'(par_err), 16'h0);
    accept("fe_accept");
    send_head(8'h96, 1'b0);
    send_stop(1'b1, 1'b0);
    chk("fe_next_data", 16'(data), 16'h96);
    chk("fe_next_frm_err", 16'(frm_err), 16'h0);
    chk("fe_next_par_err", 16'(par_err), 16'h0);
    accept("fe_next_accept");

    // Overrun: second frame dropped while the first is held
    repeat (2) @(negedge clk);
    ovr_cnt = 0;
    send_head(8'h11, 1'b0);
    send_stop(1'b1, 1'b0);
    chk("ov_first_data", 16'(data), 16'h11);
    chk("ov_first_overrun", 16'(overrun), 16'h0);
    send_head(8'h22, 1'b0);
    send_stop(1'b1, 1'b0);
    chk("ov_pulse", 16'(overrun), 16'h1);
    @(negedge clk);
    chk("ov_pulse_end", 16'(overrun), 16'h0);
    repeat (3) @(negedge clk);
    chk("ov_count", 16'(ovr_cnt), 16'h1);
    chk("ov_kept_data", 16'(data), 16'h11);
    chk("ov_kept_valid", 16'(valid), 16'h1);

    // Acceptance coinciding with completion loads the new word
    send_head(8'h33, 1'b0);
    send_stop(1'b1, 1'b1);
    chk("co_valid", 16'(valid), 16'h1);
    chk("co_data", 16'(data), 16'h33);
    repeat (2) @(negedge clk);
    chk("co_no_overrun", 16'(ovr_cnt), 16'h1);
    accept("co_accept");

    // Reset after four data bits aborts the frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_data", 16'(data), 16'h0);
    chk("mr_all_zero", 16'(all_zero), 16'h1);
    chk("mr_all_one", 16'(all_one), 16'h0);
    chk("mr_flags", {14'h0, par_err, frm_err}, 16'h0);
    chk("mr_valid", 16'(valid), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mr_no_valid", 16'(valid), 16'h0);
    chk("mr_no_overrun", 16'(ovr_cnt), 16'h1);
    send_head(8'h5A, 1'b0);
    send_stop(1'b1, 1'b0);
    chk("mr_next_valid", 16'(valid), 16'h1);
    chk("mr_next_data", 16'(data), 16'h5A);
    chk("mr_next_par_err", 16'(par_err), 16'h0);
    chk("mr_next_frm_err", 16'(frm_err), 16'h0);
    accept("mr_next_accept");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
